// File: rtl/in_out_control.sv
// Key/switch front end for the SDRAM controller: builds one read/write command from
// switch entries, strobes ioDone once, holds the command until memDone, latches read data.
module in_out_control (
  input  logic        clk,
  input  logic        rst,
  input  logic        key0_debounce,
  input  logic        key1_debounce,
  input  logic        key0_pulse,
  input  logic        key1_pulse,
  input  logic [8:0]  sw,
  input  logic        memDone,
  input  logic [15:0] read_data,
  output logic [1:0]  modeOutput,
  output logic [24:0] memoryAddress,
  output logic [15:0] write_data,
  output logic        ioDone,
  output logic        reset_out,
  output logic [15:0] display_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR0, S_ADDR1, S_ADDR2, S_DATA0, S_DATA1, S_ISSUE, S_WAIT
  } state_t;

  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] MODE_READ  = 2'b01;

  state_t      state, state_n;
  logic [1:0]  mode_r, mode_n;
  logic [24:0] addr_n;
  logic [15:0] data_n;
  logic [15:0] disp_n;
  logic        dual_key;
  logic        take;
  logic        clear_cmd;

  assign dual_key = key0_debounce & key1_debounce;
  // Abort has priority over confirm when both pulses land together.
  assign take     = key0_pulse & ~key1_pulse;

  always_comb begin
    state_n   = state;
    mode_n    = mode_r;
    addr_n    = memoryAddress;
    data_n    = write_data;
    disp_n    = display_data;
    clear_cmd = 1'b0;

    case (state)
      S_IDLE: begin
        if (take && (sw[1:0] == MODE_WRITE || sw[1:0] == MODE_READ)) begin
          mode_n  = sw[1:0];
          state_n = S_ADDR0;
        end
      end
      S_ADDR0: begin
        if (key1_pulse) clear_cmd = 1'b1;
        else if (take) begin
          addr_n[8:0] = sw;
          state_n     = S_ADDR1;
        end
      end
      S_ADDR1: begin
        if (key1_pulse) clear_cmd = 1'b1;
        else if (take) begin
          addr_n[17:9] = sw;
          state_n      = S_ADDR2;
        end
      end
      S_ADDR2: begin
        if (key1_pulse) clear_cmd = 1'b1;
        else if (take) begin
          addr_n[24:18] = sw[6:0];
          state_n       = (mode_r == MODE_WRITE) ? S_DATA0 : S_ISSUE;
        end
      end
      S_DATA0: begin
        if (key1_pulse) clear_cmd = 1'b1;
        else if (take) begin
          data_n[8:0] = sw;
          state_n     = S_DATA1;
        end
      end
      S_DATA1: begin
        if (key1_pulse) clear_cmd = 1'b1;
        else if (take) begin
          data_n[15:9] = sw[6:0];
          state_n      = S_ISSUE;
        end
      end
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (memDone) begin
          if (mode_r == MODE_READ) disp_n = read_data;
          mode_n  = 2'b00;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Holding both keys abandons everything, including a command already in WAIT.
    if (clear_cmd || dual_key) begin
      state_n = S_IDLE;
      mode_n  = 2'b00;
      addr_n  = '0;
      data_n  = '0;
      disp_n  = display_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mode_r        <= 2'b00;
      modeOutput    <= 2'b00;
      memoryAddress <= '0;
      write_data    <= '0;
      display_data  <= '0;
      ioDone        <= 1'b0;
      reset_out     <= 1'b1;
    end else begin
      state         <= state_n;
      mode_r        <= mode_n;
      modeOutput    <= (state_n == S_IDLE) ? 2'b00 : mode_n;
      memoryAddress <= addr_n;
      write_data    <= data_n;
      display_data  <= disp_n;
      ioDone        <= (state_n == S_ISSUE);
      reset_out     <= dual_key;
    end
  end

endmodule

// File: tb/tb_in_out_control.sv
// Scoreboard bench for in_out_control: expected commands are queued by the stimulus and
// popped by a monitor on each ioDone strobe; static outputs are checked directly.
module tb_in_out_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        key0_debounce, key1_debounce, key0_pulse, key1_pulse;
  logic [8:0]  sw;
  logic        memDone;
  logic [15:0] read_data;
  logic [1:0]  modeOutput;
  logic [24:0] memoryAddress;
  logic [15:0] write_data;
  logic        ioDone, reset_out;
  logic [15:0] display_data;

  typedef struct {
    logic [1:0]  mode;
    logic [24:0] addr;
    logic [15:0] data;
    bit          chk_data;
  } cmd_t;

  cmd_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   io_count = 0;

  in_out_control dut (
    .clk(clk), .rst(rst),
    .key0_debounce(key0_debounce), .key1_debounce(key1_debounce),
    .key0_pulse(key0_pulse), .key1_pulse(key1_pulse),
    .sw(sw), .memDone(memDone), .read_data(read_data),
    .modeOutput(modeOutput), .memoryAddress(memoryAddress), .write_data(write_data),
    .ioDone(ioDone), .reset_out(reset_out), .display_data(display_data)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with ioDone high must match the oldest queued command.
  always @(negedge clk) begin
    if (!rst && ioDone) begin
      io_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ioDone: got ioDone=1 expected no pending command");
      end else begin
        cmd_t e;
        e = sb.pop_front();
        chk("cmd_mode", {30'd0, modeOutput}, {30'd0, e.mode});
        chk("cmd_addr", {7'd0, memoryAddress}, {7'd0, e.addr});
        if (e.chk_data) chk("cmd_data", {16'd0, write_data}, {16'd0, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic k0(input logic [8:0] v);
    sw = v;
    key0_pulse = 1'b1;
    step();
    key0_pulse = 1'b0;
    step();
  endtask

  task automatic wait_io(input int want, input string name);
    for (int i = 0; i < 20 && io_count < want; i++) step();
    chk(name, io_count, want);
  endtask

  task automatic mem_done(input logic [15:0] d);
    read_data = d;
    memDone = 1'b1;
    step();
    memDone = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    key0_debounce = 0; key1_debounce = 0; key0_pulse = 0; key1_pulse = 0;
    sw = '0; memDone = 0; read_data = '0;
    step(); step();
    chk("rst_reset_out", {31'd0, reset_out}, 1);
    chk("rst_mode", {30'd0, modeOutput}, 0);
    chk("rst_ioDone", {31'd0, ioDone}, 0);
    chk("rst_display", {16'd0, display_data}, 0);
    chk("rst_addr", {7'd0, memoryAddress}, 0);
    rst = 1'b0;
    step();
    chk("reset_out_released", {31'd0, reset_out}, 0);

    // Dual-key reset: pulses are ignored while both keys are held.
    key0_debounce = 1; key1_debounce = 1;
    step();
    chk("dual_reset_out", {31'd0, reset_out}, 1);
    sw = 9'h002; key0_pulse = 1; step(); key0_pulse = 0;
    step();
    chk("dual_mode_ignored", {30'd0, modeOutput}, 0);
    key0_debounce = 0; key1_debounce = 0;
    step();
    chk("dual_released", {31'd0, reset_out}, 0);
    chk("dual_still_idle", {30'd0, modeOutput}, 0);

    // WRITE: addr = {sw[6:0]=03, 9'h000, 9'h1FF}, data = {7'h55, 9'h0AA}.
    sb.push_back('{mode: 2'b10, addr: 25'h00C01FF, data: 16'hAAAA, chk_data: 1'b1});
    k0(9'h002); k0(9'h1FF); k0(9'h000); k0(9'h003); k0(9'h0AA); k0(9'h055);
    wait_io(1, "write_ioDone");
    step(); step();
    key1_pulse = 1; step(); key1_pulse = 0;
    key0_pulse = 1; sw = 9'h001; step(); key0_pulse = 0;
    step(); step();
    chk("wait_mode_hold", {30'd0, modeOutput}, 2);
    chk("wait_addr_hold", {7'd0, memoryAddress}, 32'h00C01FF);
    chk("wait_data_hold", {16'd0, write_data}, 32'hAAAA);
    chk("wait_no_second_io", io_count, 1);
    mem_done(16'h1234);
    chk("write_done_mode", {30'd0, modeOutput}, 0);
    chk("write_no_display", {16'd0, display_data}, 0);

    // READ: three address entries, no data entries.
    sb.push_back('{mode: 2'b01, addr: {7'h7F, 9'h045, 9'h123}, data: 16'h0, chk_data: 1'b0});
    k0(9'h001); k0(9'h123); k0(9'h045); k0(9'h07F);
    wait_io(2, "read_ioDone");
    chk("read_mode", {30'd0, modeOutput}, 1);
    mem_done(16'hAAAA);
    chk("read_display", {16'd0, display_data}, 32'hAAAA);
    chk("read_done_mode", {30'd0, modeOutput}, 0);

    // memDone outside WAIT is ignored.
    mem_done(16'h5555);
    chk("stray_memDone", {16'd0, display_data}, 32'hAAAA);

    // Invalid mode 11 in IDLE is ignored.
    k0(9'h003);
    chk("bad_mode_idle", {30'd0, modeOutput}, 0);

    // Abort in ADDR1 with both pulses in the same cycle.
    k0(9'h001); k0(9'h005);
    chk("in_addr1_mode", {30'd0, modeOutput}, 1);
    sw = 9'h006; key0_pulse = 1; key1_pulse = 1; step();
    key0_pulse = 0; key1_pulse = 0; step();
    chk("abort_mode", {30'd0, modeOutput}, 0);
    k0(9'h0FC);
    chk("abort_then_idle", {30'd0, modeOutput}, 0);
    step(); step(); step();
    chk("abort_no_io", io_count, 2);

    // Dual-key reset while waiting for memDone abandons the command.
    sb.push_back('{mode: 2'b01, addr: {7'h03, 9'h002, 9'h001}, data: 16'h0, chk_data: 1'b0});
    k0(9'h001); k0(9'h001); k0(9'h002); k0(9'h003);
    wait_io(3, "read2_ioDone");
    key0_debounce = 1; key1_debounce = 1; step();
    key0_debounce = 0; key1_debounce = 0; step();
    chk("wait_dual_mode", {30'd0, modeOutput}, 0);
    chk("wait_dual_addr", {7'd0, memoryAddress}, 0);
    mem_done(16'h0F0F);
    chk("wait_dual_display", {16'd0, display_data}, 32'hAAAA);

    step(); step();
    chk("sb_empty", sb.size(), 0);
    chk("io_total", io_count, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
